// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives a req/gnt/rvalid data-memory port, stalls
// the pipeline for each access and aligns/extends returned load data.
module mem_stage_lsu #(
  parameter logic [7:0] MAX_WAIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        acc_fault,
  output logic        bus_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        err_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        access;
  logic        fault;
  logic        accept;
  logic        timeout;
  logic        to_evt;

  function automatic logic illegal(input logic rd, input logic wr,
                                   input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (rd && wr) bad = 1'b1;
    if (wr && (f3 > 3'b010)) bad = 1'b1;
    if (rd && ((f3 == 3'b011) || (f3[2:1] == 2'b11))) bad = 1'b1;
    if ((f3[1:0] == 2'b01) && off[0]) bad = 1'b1;
    if ((f3[1:0] == 2'b10) && (off != 2'b00)) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign access  = ex_valid & (mem_read | mem_write);
  assign fault   = illegal(mem_read, mem_write, funct3, addr[1:0]);
  assign timeout = (cnt == (MAX_WAIT - 8'd1));
  assign to_evt  = ((state == REQ) && !dm_gnt && timeout) ||
                   ((state == RESP) && !dm_rvalid && timeout);

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    acc_fault = 1'b0;
    bus_err   = 1'b0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = '0;
    dm_be     = '0;
    dm_wdata  = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (fault) begin
            acc_fault = 1'b1;
          end else begin
            stall     = 1'b1;
            accept    = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        stall    = 1'b1;
        dm_req   = 1'b1;
        dm_we    = we_q;
        dm_addr  = {addr_q[31:2], 2'b00};
        dm_be    = byte_en(f3_q[1:0], addr_q[1:0]);
        dm_wdata = store_data(f3_q[1:0], wdata_q);
        if (dm_gnt)       state_nxt = RESP;
        else if (timeout) state_nxt = DONE;
      end
      RESP: begin
        stall = 1'b1;
        if (dm_rvalid || timeout) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        bus_err   = err_q;
        state_nxt = IDLE;
      end
    endcase
  end

  // Control and load-result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      err_q <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt   <= '0;
        err_q <= 1'b0;
      end else if ((state == REQ) || (state == RESP)) begin
        cnt <= cnt + 8'd1;
      end
      if (to_evt) begin
        err_q <= 1'b1;
        if (!we_q) rdata <= '0;
      end else if ((state == RESP) && dm_rvalid && !we_q) begin
        rdata <= load_ext(f3_q, addr_q[1:0], dm_rdata);
      end
    end
  end

  // Access capture; only meaningful once accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      f3_q    <= funct3;
      we_q    <= mem_write;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu with a short bus timeout (MAX_WAIT=4).
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, acc_fault, bus_err;
  logic [31:0] rdata;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic [3:0]  dm_be;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd = 32'd0;

  mem_stage_lsu #(.MAX_WAIT(8'd4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .rdata(rdata), .acc_fault(acc_fault),
    .bus_err(bus_err), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Pop one expected result per completed access
  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("rdata", rdata, e.rd);
        check("bus_err", {31'd0, bus_err}, {31'd0, e.err});
      end
    end
  end

  // gw: REQ cycles before gnt; rw: RESP cycles before rvalid (large = never)
  task automatic acc(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int gw, input int rw, input logic [31:0] rdat,
                     input logic [3:0] ebe, input logic [31:0] ewd,
                     input logic [31:0] erd);
    int   c;
    logic err, got_gnt, pred_err;
    exp_t x;
    pred_err = (gw > 3) || (gw + 1 + rw > 3);
    x.err = pred_err;
    x.rd  = rd ? (pred_err ? 32'd0 : erd) : last_rd;
    last_rd = x.rd;
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    sb.push_back(x);
    @(negedge clk);
    check("accept_stall", {31'd0, stall}, 32'd1);
    check("accept_fault", {31'd0, acc_fault}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    c = 0; err = 1'b0; got_gnt = 1'b0;
    for (int i = 0; !got_gnt && !err; i++) begin
      dm_gnt = (i == gw);
      @(negedge clk);
      check("dm_req", {31'd0, dm_req}, 32'd1);
      check("dm_addr", dm_addr, {a[31:2], 2'b00});
      check("dm_be", {28'd0, dm_be}, {28'd0, ebe});
      check("dm_we", {31'd0, dm_we}, {31'd0, wr});
      check("req_stall", {31'd0, stall}, 32'd1);
      if (wr) check("dm_wdata", dm_wdata, ewd);
      @(posedge clk); #1;
      dm_gnt = 1'b0;
      if (i == gw) got_gnt = 1'b1;
      else if (c == 3) err = 1'b1;
      c++;
    end
    if (got_gnt) begin
      for (int j = 0; ; j++) begin
        dm_rvalid = (j == rw);
        dm_rdata  = rdat;
        @(negedge clk);
        check("resp_req", {31'd0, dm_req}, 32'd0);
        check("resp_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        dm_rvalid = 1'b0;
        if (j == rw) break;
        if (c == 3) break;
        c++;
      end
    end
    @(negedge clk);
    check("done_stall", {31'd0, stall}, 32'd0);
    check("done_pulse", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("idle_done", {31'd0, done}, 32'd0);
  endtask

  task automatic flt(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    ex_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a;
    @(negedge clk);
    check("fault_pulse", {31'd0, acc_fault}, 32'd1);
    check("fault_stall", {31'd0, stall}, 32'd0);
    check("fault_req", {31'd0, dm_req}, 32'd0);
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("fault_after_req", {31'd0, dm_req}, 32'd0);
    check("fault_after_pulse", {31'd0, acc_fault}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_req", {31'd0, dm_req}, 32'd0);
    check("rst_fault", {31'd0, acc_fault}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    acc(1, 0, 3'b010, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF);
    acc(0, 1, 3'b000, 32'h203, 32'h12345678, 0, 0, 32'h0,        4'b1000, 32'h78787878, 32'h0);
    acc(1, 0, 3'b000, 32'h001, 32'h0,        0, 0, 32'h00008000, 4'b0010, 32'h0,        32'hFFFFFF80);
    acc(1, 0, 3'b101, 32'h002, 32'h0,        0, 0, 32'hABCD0000, 4'b1100, 32'h0,        32'h0000ABCD);
    acc(0, 1, 3'b001, 32'h002, 32'h1234ABCD, 0, 0, 32'h0,        4'b1100, 32'hABCDABCD, 32'h0);
    acc(1, 0, 3'b100, 32'h003, 32'h0,        1, 1, 32'h80000000, 4'b1000, 32'h0,        32'h00000080);
    acc(1, 0, 3'b001, 32'h000, 32'h0,        0, 0, 32'h0000F00F, 4'b0011, 32'h0,        32'hFFFFF00F);
    acc(0, 1, 3'b010, 32'h010, 32'hCAFEF00D, 2, 0, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0);
    acc(1, 0, 3'b010, 32'h300, 32'h0,       99, 0, 32'h11111111, 4'b1111, 32'h0,        32'h0);
    acc(1, 0, 3'b010, 32'h304, 32'h0,        0, 99, 32'h22222222, 4'b1111, 32'h0,       32'h0);
    acc(1, 0, 3'b010, 32'h308, 32'h0,        0, 0, 32'h5A5A1234, 4'b1111, 32'h0,        32'h5A5A1234);

    flt(1, 0, 3'b001, 32'h101);
    flt(1, 1, 3'b010, 32'h100);
    flt(1, 0, 3'b010, 32'h102);
    flt(0, 1, 3'b100, 32'h100);
    flt(1, 0, 3'b011, 32'h100);

    // Reset in RESP: everything drops at once and a late rvalid is ignored
    ex_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0; dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_stall", {31'd0, stall}, 32'd0);
    check("mid_rst_req", {31'd0, dm_req}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'h99999999;
    @(negedge clk);
    check("late_rv_done", {31'd0, done}, 32'd0);
    check("late_rv_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    @(negedge clk);
    check("late_rv_done2", {31'd0, done}, 32'd0);
    check("late_rv_rdata", rdata, 32'd0);
    @(posedge clk); #1;

    check("sb_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
